mux_rr_sched: RTL and testbench
===============================

# mux_rr_sched

Round-robin scheduler that shares one N:1 bit multiplexer (the `mux_7`/`mux_3` datapath) among N requesters. It decides which input owns the mux output and drives the mux select `s` plus a one-hot grant and valid flag. An optional hold limit keeps one owner from monopolising the mux. All outputs are registered, so the mux select never glitches and is always a legal index.

## Interface

Parameters:
- `N`, 7: number of requesters / mux inputs, 2..8.
- `SW`, 3: select width, equal to ceil(log2 N).
- `MAXHOLD`, 8: maximum consecutive grant cycles while others wait. 0 means unlimited.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: per-requester request, level-sensitive.
- `s` out SW: mux select, binary index of the current or last owner.
- `gnt` out N: one-hot grant, all zero when idle.
- `vld` out 1: high when `gnt` is non-zero, so the mux output is owned.

## Operation

- Reset values: `s`=0, `gnt`=0, `vld`=0, state IDLE, `last`=N-1, `cnt`=0.
- State IDLE: if `req` is non-zero, pick the winner as the first set bit searching upward from `last`+1 mod N. Go to GRANT and set `gnt`, `s` and `vld` for that winner. Otherwise stay in IDLE.
- State GRANT with owner `i`:
  - **Release:** when `req[i]` is sampled low:
    - If other requests are pending, hand over directly to the next winner, searching from `i`+1 with no idle bubble.
    - Otherwise go to IDLE with `gnt`=0 and `vld`=0.
    - In both cases `last`=`i`.
  - **Forced rotation:** when `MAXHOLD`≠0, `cnt`==`MAXHOLD`-1, `req[i]` is still high and some other `req[j]` is high, grant the next winner searching from `i`+1. `i` keeps lowest priority for that search.
  - **No contention:** if only `req[i]` is high, `i` keeps the grant. `cnt` saturates at `MAXHOLD`-1 and rotation happens on the first cycle another request appears.
- `cnt` clears to 0 on every new grant, including handover. It increments each GRANT cycle where the owner keeps the grant.
- `s` always lies in 0..N-1, so the mux never sees an out-of-range select. In IDLE, `s` holds the last owner index.
- Requests with bit index ≥ N do not exist. The search loops modulo N only.

## Timing

- Latency from a request in IDLE to grant: 1 cycle. `req` is sampled at edge k and `gnt`, `s` and `vld` are valid after edge k.
- Latency from release to the next grant: 1 cycle, with no dead cycle between owners.
- With `req` steady and all N bits high, each owner holds the grant for exactly `MAXHOLD` cycles, in order 0,1,…,N-1,0.
- Owner drop and another request rising in the same cycle: this counts as a handover to that requester.
- Release and hold limit hit in the same cycle: the release rule wins. The result is identical either way because the search starts from `i`+1.
- Reset asserted mid-grant: at the next edge all outputs return to reset values, regardless of `req`.

## Structure

- Package `mux_sched_pkg` holds:
  - the state enum `{IDLE, GRANT}`;
  - the `onehot_to_idx` function.
- Sub-module `rr_pick`: combinational rotate-priority finder. Inputs are `req` and `start`. Outputs are `idx` and `any`. Instantiate it once; its `start` is muxed between `last`+1 and `i`+1.
- The top level contains the FSM, the `cnt`, `last` and `s` registers, and the one-hot decode of `gnt`.

## Test plan

- **Reset:** hold `rst`=1 for 2 cycles with `req`=7'h7F. Required: `s`=0, `gnt`=0, `vld`=0 throughout. After release, the first grant is `gnt`=7'h01 and `s`=0 one cycle later.
- **Single requester:** `req`=7'h10, held for 20 cycles, then dropped. Required: `gnt`=7'h10 and `s`=4 for 20 cycles, no forced rotation, then `vld`=0 one cycle after the drop.
- **Full contention:** `MAXHOLD`=8, `req`=7'h7F. Required: grants rotate 0→1→…→6→0 with exactly 8 cycles each and no gap.
- **Early release:** owner 2, `req`=7'h24. Drop bit 2 after 3 cycles. Required: the grant moves to 5 (`s`=5) on the next cycle and `cnt` restarts.
- **Wrap-around:** owner 6 releases while `req`=7'h03. Required: the next grant goes to 0, not 1.
- **Reset mid-grant:** assert `rst` while `s`=3 and `vld`=1. Required: outputs clear at the next edge, and the post-reset search starts at index 0.

Source files
------------

// File: rtl/mux_rr_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
// Supports up to MAX_N requesters, so MAX_SW select bits always suffice.
package mux_sched_pkg;

   localparam int MAX_N  = 8;
   localparam int MAX_SW = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   function automatic logic [MAX_SW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [MAX_SW-1:0] idx;
      idx = '0;
      for (int k = 0; k < MAX_N; k++) begin
         if (oh[k]) idx = idx | MAX_SW'(k);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// Request/grant bundle between the requesters (master) and the scheduler (slave).
interface mux_rr_sched_if #(
   parameter int N  = 7,
   parameter int SW = 3
);
   // req is level-sensitive and held while a requester wants the mux; no ready
   // handshake exists. vld qualifies gnt/s: gnt is one-hot and s is its index
   // while vld=1. With vld=0, gnt is zero and s keeps the last owner's index.
   logic [N-1:0]  req;
   logic [SW-1:0] s;
   logic [N-1:0]  gnt;
   logic          vld;

   modport master (output req, input s, gnt, vld);
   modport slave  (input req, output s, gnt, vld);
endinterface

// File: rtl/mux_rr_sched_rr_pick.sv
// Rotate-priority finder: first set bit of req_i, searching upward from start_i modulo N.
module rr_pick #(
   parameter int N  = 7,
   parameter int SW = 3
) (
   input  logic [N-1:0]  req_i,
   input  logic [SW-1:0] start_i,
   output logic [SW-1:0] idx_o,
   output logic          any_o
);

   int pos;

   // Walk from the farthest position back to start_i; the last hit is the nearest one.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      pos   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(start_i) + k;
         if (pos >= N) pos = pos - N;
         if (req_i[pos]) begin
            idx_o = SW'(pos);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin owner scheduler for a shared N:1 mux with an optional hold limit.
// All outputs are registered, so s is glitch-free and always a legal index.
module mux_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int N       = 7,
   parameter int SW      = 3,
   parameter int MAXHOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   mux_rr_sched_if.slave bus,
   output state_e      state_o
);

   localparam int            CW      = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);
   localparam logic [SW-1:0] LAST_IX = SW'(N - 1);

   state_e        state_q;
   logic [SW-1:0] s_q;
   logic [N-1:0]  gnt_q;
   logic          vld_q;
   logic [SW-1:0] last_q;
   logic [CW-1:0] cnt_q;

   logic [SW-1:0] owner;
   logic [SW-1:0] start;
   logic [SW-1:0] pick_idx;
   logic          pick_any;
   logic [N-1:0]  pick_oh;
   logic          owner_drop;
   logic          others;
   logic          hold_hit;

   function automatic logic [SW-1:0] inc_mod(input logic [SW-1:0] x);
      return (int'(x) == N - 1) ? '0 : x + 1'b1;
   endfunction

   assign owner      = SW'(onehot_to_idx(MAX_N'(gnt_q)));
   // After a grant the search begins past the owner, so the owner is always last in line.
   assign start      = (state_q == IDLE) ? inc_mod(last_q) : inc_mod(owner);
   assign owner_drop = !bus.req[owner];
   assign others     = |(bus.req & ~gnt_q);
   assign hold_hit   = (MAXHOLD != 0) && (cnt_q == CNT_MAX);
   assign pick_oh    = N'(1) << pick_idx;

   rr_pick #(.N(N), .SW(SW)) u_pick (
      .req_i   (bus.req),
      .start_i (start),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= LAST_IX;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  state_q <= GRANT;
                  s_q     <= pick_idx;
                  gnt_q   <= pick_oh;
                  vld_q   <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            GRANT: begin
               if (owner_drop || (hold_hit && others)) begin
                  last_q <= owner;
                  cnt_q  <= '0;
                  if (pick_any) begin
                     s_q   <= pick_idx;
                     gnt_q <= pick_oh;
                  end else begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                     vld_q   <= 1'b0;
                  end
               end else if ((MAXHOLD != 0) && (cnt_q != CNT_MAX)) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.s   = s_q;
   assign bus.gnt = gnt_q;
   assign bus.vld = vld_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched (N=7, MAXHOLD=8) with hand-computed grant sequences.
module tb_mux_rr_sched;
   import mux_sched_pkg::*;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_e state;
   int     n_checks = 0;
   int     n_errors = 0;

   mux_rr_sched_if #(.N(7), .SW(3)) bus ();

   mux_rr_sched #(.N(7), .SW(3), .MAXHOLD(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [6:0] gnt, input logic [2:0] s,
                            input logic vld);
      check({tag, ".gnt"}, 32'(bus.gnt), 32'(gnt));
      check({tag, ".s"},   32'(bus.s),   32'(s));
      check({tag, ".vld"}, 32'(bus.vld), 32'(vld));
   endtask

   initial begin
      bus.req = 7'h7F;
      rst     = 1'b1;

      // reset held two cycles with every request high
      tick(); check_out("rst0", 7'h00, 3'd0, 1'b0);
      tick(); check_out("rst1", 7'h00, 3'd0, 1'b0);
      check("rst_state", 32'(state), 32'(IDLE));
      rst = 1'b0;
      tick(); check_out("first_grant", 7'h01, 3'd0, 1'b1);
      check("grant_state", 32'(state), 32'(GRANT));

      // full contention: 8 cycles per owner, 0..6 then wrap to 0, no gap
      for (int c = 0; c < 64; c++) begin
         logic [2:0] ow;
         ow = 3'((c / 8) % 7);
         check_out($sformatf("rot%0d", c), 7'(7'h01 << ow), ow, 1'b1);
         tick();
      end
      check_out("rot_wrap", 7'h02, 3'd1, 1'b1);

      // clean restart, then single requester 4 held 20 cycles
      rst = 1'b1; bus.req = 7'h00;
      tick(); check_out("rst2", 7'h00, 3'd0, 1'b0);
      rst = 1'b0;
      tick(); check_out("idle", 7'h00, 3'd0, 1'b0);
      bus.req = 7'h10;
      for (int c = 0; c < 20; c++) begin
         tick(); check_out($sformatf("single%0d", c), 7'h10, 3'd4, 1'b1);
      end
      bus.req = 7'h00;
      tick(); check_out("single_drop", 7'h00, 3'd4, 1'b0);
      check("drop_state", 32'(state), 32'(IDLE));

      // early release: search from 5 reaches 2 only after wrapping
      bus.req = 7'h04;
      tick(); check_out("own2", 7'h04, 3'd2, 1'b1);
      bus.req = 7'h24;
      tick(); check_out("own2_c1", 7'h04, 3'd2, 1'b1);
      tick(); check_out("own2_c2", 7'h04, 3'd2, 1'b1);
      bus.req = 7'h20;
      tick(); check_out("handover5", 7'h20, 3'd5, 1'b1);
      // bit 2 returns: owner 5 must still get a full 8-cycle hold
      bus.req = 7'h24;
      for (int c = 1; c < 8; c++) begin
         tick(); check_out($sformatf("hold5_%0d", c), 7'h20, 3'd5, 1'b1);
      end
      tick(); check_out("rotate_to2", 7'h04, 3'd2, 1'b1);

      // drop and rise in the same cycle is a handover; then wrap 6 -> 0
      bus.req = 7'h40;
      tick(); check_out("handover6", 7'h40, 3'd6, 1'b1);
      bus.req = 7'h43;
      tick(); check_out("own6_keep", 7'h40, 3'd6, 1'b1);
      bus.req = 7'h03;
      tick(); check_out("wrap_to0", 7'h01, 3'd0, 1'b1);

      // reset mid-grant while owner 3 is active
      bus.req = 7'h08;
      tick(); check_out("own3", 7'h08, 3'd3, 1'b1);
      rst = 1'b1; bus.req = 7'h7F;
      tick(); check_out("rst_mid", 7'h00, 3'd0, 1'b0);
      check("rst_mid_state", 32'(state), 32'(IDLE));
      rst = 1'b0;
      tick(); check_out("post_rst", 7'h01, 3'd0, 1'b1);

      // lone owner saturates; a newcomer rotates in on its first cycle
      bus.req = 7'h01;
      for (int c = 0; c < 12; c++) begin
         tick(); check_out($sformatf("sat%0d", c), 7'h01, 3'd0, 1'b1);
      end
      bus.req = 7'h03;
      tick(); check_out("sat_rotate", 7'h02, 3'd1, 1'b1);
      bus.req = 7'h00;
      tick(); check_out("final_idle", 7'h00, 3'd1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
